// File: rtl/imem_fetch_port.sv
// imem_fetch_port
//   Instruction memory with a registered fetch port, a run-time load port and
//   fault reporting. Sits between the PC/fetch stage and decode.
//
//   Ports
//     clk, rst            clock; synchronous active-high reset (fetch control only)
//     fetch_req/addr      fetch request and address (byte or word address)
//     stall               hold every fetch pipeline register
//     flush               kill all in-flight fetches (wins over stall)
//     instr/instr_valid   fetched word and its valid flag (NOP when not valid)
//     fault               fetch was misaligned or out of range (instr = NOP)
//     load_en/idx/data    word write into the array, independent of stall/flush/rst
//
//   Latency is one edge with OUT_REG=0, two edges with OUT_REG=1.
module imem_fetch_port #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 128,
  parameter int                 ADDR_W    = 32,
  parameter bit                 BYTE_ADDR = 1'b1,
  parameter bit                 OUT_REG   = 1'b0,
  parameter logic [DATA_W-1:0]  NOP       = {DATA_W{1'b0}},
  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fault,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [DATA_W-1:0] load_data
);

  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return BYTE_ADDR ? (a >> 2) : a;
  endfunction

  // Full-width compare: large addresses must fault rather than wrap into the array.
  function automatic logic idx_fault(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] w);
    logic misaligned;
    logic out_of_range;
    misaligned   = BYTE_ADDR && (a[1:0] != 2'b00);
    out_of_range = ({1'b0, w} >= (ADDR_W+1)'(DEPTH));
    return misaligned || out_of_range;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] fidx;
  logic [IDX_W-1:0]  rd_idx;
  logic              fetch_flt;
  logic              accept;
  logic              load_ok;
  logic              fwd;

  assign fidx      = word_idx(fetch_addr);
  assign rd_idx    = fidx[IDX_W-1:0];
  assign fetch_flt = idx_fault(fetch_addr, fidx);
  assign accept    = fetch_req && !stall && !flush && !rst;
  assign load_ok   = ({1'b0, load_idx} < (IDX_W+1)'(DEPTH));
  // Same-edge load to the fetched word returns the new data (write-first).
  assign fwd       = load_en && load_ok && (load_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  // ---- stage 1: array read ----
  logic              vld_p1;
  logic              flt_p1;
  logic [DATA_W-1:0] data_p1;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1 <= 1'b0;
      flt_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= fetch_req;
      flt_p1 <= fetch_req && fetch_flt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !fetch_flt) begin
      data_p1 <= fwd ? load_data : mem[rd_idx];
    end
  end

  logic              vld_o;
  logic              flt_o;
  logic [DATA_W-1:0] data_o;

  generate
    if (OUT_REG) begin : g_out_reg
      // ---- stage 2: output register ----
      logic              vld_p2;
      logic              flt_p2;
      logic [DATA_W-1:0] data_p2;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld_p2 <= 1'b0;
          flt_p2 <= 1'b0;
        end else if (!stall) begin
          vld_p2 <= vld_p1;
          flt_p2 <= flt_p1;
        end
      end

      always_ff @(posedge clk) begin
        if (!stall && vld_p1 && !flt_p1) begin
          data_p2 <= data_p1;
        end
      end

      assign vld_o  = vld_p2;
      assign flt_o  = flt_p2;
      assign data_o = data_p2;
    end else begin : g_no_out_reg
      assign vld_o  = vld_p1;
      assign flt_o  = flt_p1;
      assign data_o = data_p1;
    end
  endgenerate

  // Data registers carry no reset; NOP is substituted whenever the slot is
  // empty or faulted, which also gives the reset value of instr.
  assign instr_valid = vld_o;
  assign fault       = flt_o;
  assign instr       = (vld_o && !flt_o) ? data_o : NOP;

endmodule
